// File: rtl/frog_game_pkg.sv
// Shared encodings and grid geometry for the lane-crossing game sequencer.
package frog_game_pkg;

  typedef enum logic [1:0] {
    QI      = 2'b00,
    QGAME_1 = 2'b01,
    QGAME_2 = 2'b10,
    QDONE   = 2'b11
  } game_state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10
  } winner_t;

  localparam int COLS_DEF = 20;
  localparam int ROWS_DEF = 15;
  localparam int ROW_W    = 4;
  localparam int COL_W    = 5;
  localparam int SCORE_W  = 4;

  // A turn always hands over to the opposite player's game state.
  function automatic game_state_t other_player(input game_state_t s);
    return (s == QGAME_1) ? QGAME_2 : QGAME_1;
  endfunction

endpackage

// File: rtl/frog_pos_reg.sv
// Player grid position: saturating single-step moves, respawn overrides everything.
module frog_pos_reg
  import frog_game_pkg::*;
#(
  parameter int COLS      = COLS_DEF,
  parameter int ROWS      = ROWS_DEF,
  parameter int START_COL = 9,
  parameter int START_ROW = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             move_tick,
  input  logic             btnU,
  input  logic             btnD,
  input  logic             btnL,
  input  logic             btnR,
  input  logic             move_en,
  input  logic             respawn,
  output logic [ROW_W-1:0] player_row,
  output logic [COL_W-1:0] player_col
);

  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] START_R = ROW_W'(START_ROW);
  localparam logic [COL_W-1:0] START_C = COL_W'(START_COL);

  // The first pressed direction claims the tick even when it is pinned at an edge.
  always_ff @(posedge clk) begin
    if (reset || respawn) begin
      player_row <= START_R;
      player_col <= START_C;
    end else if (move_en && move_tick) begin
      if (btnD && !btnU) begin
        if (player_row != ROW_MAX) player_row <= player_row + 1'b1;
      end else if (btnU && !btnD) begin
        if (player_row != '0) player_row <= player_row - 1'b1;
      end else if (btnR && !btnL) begin
        if (player_col != COL_MAX) player_col <= player_col + 1'b1;
      end else if (btnL && !btnR) begin
        if (player_col != '0) player_col <= player_col - 1'b1;
      end
    end
  end

endmodule

// File: rtl/frog_game_ctrl.sv
// Turn, score and collision sequencer; owns the player position through frog_pos_reg.
module frog_game_ctrl
  import frog_game_pkg::*;
#(
  parameter int COLS      = COLS_DEF,
  parameter int ROWS      = ROWS_DEF,
  parameter int START_COL = 9,
  parameter int START_ROW = 14,
  parameter int GOAL_ROW  = 0,
  parameter int WIN_SCORE = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               move_tick,
  input  logic               btnU,
  input  logic               btnD,
  input  logic               btnL,
  input  logic               btnR,
  input  logic [COLS-1:0]    obs_bits,
  output logic [1:0]         state,
  output logic [ROW_W-1:0]   player_row,
  output logic [COL_W-1:0]   player_col,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic               obs_reload,
  output logic               obs_shift_en,
  output logic               collide,
  output logic [1:0]         winner
);

  localparam logic [ROW_W-1:0]   GOAL_R = ROW_W'(GOAL_ROW);
  localparam logic [SCORE_W-1:0] WIN_S  = SCORE_W'(WIN_SCORE);

  game_state_t        state_q;
  winner_t            winner_q;
  logic               in_game;
  logic               hit;
  logic               at_goal;
  logic               respawn;
  logic               move_en;
  logic [SCORE_W-1:0] score_inc;

  assign in_game   = (state_q == QGAME_1) || (state_q == QGAME_2);
  assign hit       = in_game && obs_bits[player_col];
  assign at_goal   = in_game && (player_row == GOAL_R);
  assign score_inc = ((state_q == QGAME_1) ? p1_score : p2_score) + 1'b1;

  // An abort, hit or goal sends the frog home; QI keeps it parked there.
  assign respawn = (state_q == QI) || (in_game && (!start || hit || at_goal));
  assign move_en = in_game && start && !hit && !at_goal;

  assign state        = state_q;
  assign winner       = winner_q;
  assign obs_shift_en = in_game;

  frog_pos_reg #(
    .COLS      (COLS),
    .ROWS      (ROWS),
    .START_COL (START_COL),
    .START_ROW (START_ROW)
  ) u_pos (
    .clk        (clk),
    .reset      (reset),
    .move_tick  (move_tick),
    .btnU       (btnU),
    .btnD       (btnD),
    .btnL       (btnL),
    .btnR       (btnR),
    .move_en    (move_en),
    .respawn    (respawn),
    .player_row (player_row),
    .player_col (player_col)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= QI;
      winner_q   <= WIN_NONE;
      p1_score   <= '0;
      p2_score   <= '0;
      obs_reload <= 1'b0;
      collide    <= 1'b0;
    end else begin
      obs_reload <= 1'b0;
      collide    <= 1'b0;
      case (state_q)
        QI: begin
          if (start) begin
            state_q    <= QGAME_1;
            winner_q   <= WIN_NONE;
            p1_score   <= '0;
            p2_score   <= '0;
            obs_reload <= 1'b1;
          end
        end
        QGAME_1, QGAME_2: begin
          if (!start) begin
            state_q <= QI;
          end else if (hit) begin
            collide <= 1'b1;
            state_q <= other_player(state_q);
          end else if (at_goal) begin
            if (state_q == QGAME_1) p1_score <= score_inc;
            else                    p2_score <= score_inc;
            if (score_inc == WIN_S) begin
              state_q  <= QDONE;
              winner_q <= (state_q == QGAME_1) ? WIN_P1 : WIN_P2;
            end else begin
              state_q <= other_player(state_q);
            end
          end
        end
        QDONE: begin
          if (!start) state_q <= QI;
        end
        default: state_q <= QI;
      endcase
    end
  end

endmodule

// File: tb/tb_frog_game_ctrl.sv
// Directed scenarios plus a randomized run against a behavioural game model.
module tb_frog_game_ctrl;

  localparam int COLS = 20;
  localparam int ROWS = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        move_tick = 1'b0;
  logic        btnU = 1'b0, btnD = 1'b0, btnL = 1'b0, btnR = 1'b0;
  logic [19:0] obs_bits;
  logic [1:0]  state;
  logic [3:0]  player_row;
  logic [4:0]  player_col;
  logic [3:0]  p1_score, p2_score;
  logic        obs_reload, obs_shift_en, collide;
  logic [1:0]  winner;

  logic        use_table = 1'b0;
  logic [19:0] obs_direct = '0;
  logic [19:0] obs_table [16];

  int n_compared = 0;
  int n_mismatched = 0;

  // Reference model state
  int m_state, m_row, m_col, m_p1, m_p2, m_win, m_reload, m_collide;

  frog_game_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .move_tick    (move_tick),
    .btnU         (btnU),
    .btnD         (btnD),
    .btnL         (btnL),
    .btnR         (btnR),
    .obs_bits     (obs_bits),
    .state        (state),
    .player_row   (player_row),
    .player_col   (player_col),
    .p1_score     (p1_score),
    .p2_score     (p2_score),
    .obs_reload   (obs_reload),
    .obs_shift_en (obs_shift_en),
    .collide      (collide),
    .winner       (winner)
  );

  always #5 clk = ~clk;

  // Stand-in for the datapath: the obstacle row follows the player's row.
  always_comb begin
    obs_bits = use_table ? obs_table[player_row] : obs_direct;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic move_once(input logic u, input logic d, input logic l, input logic r);
    btnU = u; btnD = d; btnL = l; btnR = r;
    move_tick = 1'b1;
    cycle();
    move_tick = 1'b0;
    {btnU, btnD, btnL, btnR} = 4'b0;
  endtask

  task automatic goal_run();
    for (int i = 0; i < 14; i++) move_once(1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
  endtask

  task automatic hit_run();
    obs_direct = 20'd1 << 9;
    cycle();
    obs_direct = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    n_compared++;
    if (state !== 2'b00) begin n_mismatched++; $display("[TB] FAIL reset_state: got %0d expected 0", state); end
    n_compared++;
    if (player_row !== 4'd14 || player_col !== 5'd9) begin
      n_mismatched++; $display("[TB] FAIL reset_pos: got (%0d,%0d) expected (14,9)", player_row, player_col);
    end
    n_compared++;
    if (p1_score !== 4'd0 || p2_score !== 4'd0 || winner !== 2'b00) begin
      n_mismatched++; $display("[TB] FAIL reset_score: got %0d/%0d w%0d expected 0/0 w0", p1_score, p2_score, winner);
    end
    n_compared++;
    if (obs_reload !== 1'b0 || collide !== 1'b0 || obs_shift_en !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL reset_pulses: got %b%b%b expected 000", obs_reload, collide, obs_shift_en);
    end
  endtask

  task automatic test_start();
    start = 1'b1;
    cycle();
    n_compared++;
    if (state !== 2'b01 || obs_reload !== 1'b1) begin
      n_mismatched++; $display("[TB] FAIL start_enter: got state %0d reload %b expected 1 1", state, obs_reload);
    end
    cycle();
    n_compared++;
    if (obs_reload !== 1'b0 || obs_shift_en !== 1'b1) begin
      n_mismatched++; $display("[TB] FAIL start_reload_pulse: got reload %b shift %b expected 0 1", obs_reload, obs_shift_en);
    end
    n_compared++;
    if (player_row !== 4'd14 || player_col !== 5'd9 || p1_score !== 4'd0 || p2_score !== 4'd0) begin
      n_mismatched++; $display("[TB] FAIL start_pos: got (%0d,%0d) %0d/%0d expected (14,9) 0/0", player_row, player_col, p1_score, p2_score);
    end
  endtask

  task automatic test_goal();
    obs_direct = '0;
    for (int i = 0; i < 14; i++) move_once(1'b1, 1'b0, 1'b0, 1'b0);
    n_compared++;
    if (player_row !== 4'd0 || state !== 2'b01) begin
      n_mismatched++; $display("[TB] FAIL goal_reach: got row %0d state %0d expected 0 1", player_row, state);
    end
    cycle();
    n_compared++;
    if (p1_score !== 4'd1 || state !== 2'b10 || player_row !== 4'd14 || player_col !== 5'd9) begin
      n_mismatched++; $display("[TB] FAIL goal_score: got p1 %0d state %0d (%0d,%0d) expected 1 2 (14,9)", p1_score, state, player_row, player_col);
    end
  endtask

  task automatic test_collision();
    obs_direct = 20'd1 << 9;
    btnU = 1'b1;
    move_tick = 1'b1;
    cycle();
    move_tick = 1'b0;
    btnU = 1'b0;
    obs_direct = '0;
    n_compared++;
    if (collide !== 1'b1 || player_row !== 4'd14 || state !== 2'b01 || p2_score !== 4'd0) begin
      n_mismatched++; $display("[TB] FAIL collide_hit: got c%b row %0d state %0d p2 %0d expected 1 14 1 0", collide, player_row, state, p2_score);
    end
    cycle();
    n_compared++;
    if (collide !== 1'b0) begin n_mismatched++; $display("[TB] FAIL collide_pulse: got %b expected 0", collide); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 12; i++) move_once(1'b0, 1'b0, 1'b1, 1'b0);
    n_compared++;
    if (player_col !== 5'd0 || player_row !== 4'd14) begin
      n_mismatched++; $display("[TB] FAIL sat_left: got (%0d,%0d) expected (14,0)", player_row, player_col);
    end
    move_once(1'b1, 1'b0, 1'b1, 1'b1);
    n_compared++;
    if (player_row !== 4'd13 || player_col !== 5'd0) begin
      n_mismatched++; $display("[TB] FAIL sat_pair: got (%0d,%0d) expected (13,0)", player_row, player_col);
    end
    move_once(1'b0, 1'b1, 1'b0, 1'b0);
    move_once(1'b0, 1'b1, 1'b0, 1'b0);
    n_compared++;
    if (player_row !== 4'd14) begin n_mismatched++; $display("[TB] FAIL sat_bottom: got %0d expected 14", player_row); end
    move_once(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_win();
    for (int i = 0; i < 13; i++) move_once(1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    hit_run();
    for (int i = 0; i < 7; i++) begin
      goal_run();
      hit_run();
    end
    n_compared++;
    if (p1_score !== 4'd9 || state !== 2'b01) begin
      n_mismatched++; $display("[TB] FAIL win_pre: got p1 %0d state %0d expected 9 1", p1_score, state);
    end
    goal_run();
    n_compared++;
    if (p1_score !== 4'd10 || state !== 2'b11 || winner !== 2'b01 || obs_shift_en !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL win_done: got p1 %0d state %0d w %0d shift %b expected 10 3 1 0", p1_score, state, winner, obs_shift_en);
    end
    move_once(1'b1, 1'b0, 1'b0, 1'b0);
    n_compared++;
    if (player_row !== 4'd14 || state !== 2'b11) begin
      n_mismatched++; $display("[TB] FAIL win_frozen: got row %0d state %0d expected 14 3", player_row, state);
    end
    start = 1'b0;
    cycle();
    n_compared++;
    if (state !== 2'b00 || p1_score !== 4'd10 || winner !== 2'b01) begin
      n_mismatched++; $display("[TB] FAIL win_idle: got state %0d p1 %0d w %0d expected 0 10 1", state, p1_score, winner);
    end
    start = 1'b1;
    cycle();
    n_compared++;
    if (state !== 2'b01 || p1_score !== 4'd0 || winner !== 2'b00 || obs_reload !== 1'b1) begin
      n_mismatched++; $display("[TB] FAIL win_restart: got state %0d p1 %0d w %0d r %b expected 1 0 0 1", state, p1_score, winner, obs_reload);
    end
    cycle();
  endtask

  task automatic test_reset_midgame();
    for (int i = 0; i < 3; i++) begin
      goal_run();
      goal_run();
    end
    hit_run();
    goal_run();
    hit_run();
    n_compared++;
    if (state !== 2'b10 || p1_score !== 4'd3 || p2_score !== 4'd4) begin
      n_mismatched++; $display("[TB] FAIL mid_pre: got state %0d %0d/%0d expected 2 3/4", state, p1_score, p2_score);
    end
    move_once(1'b1, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    n_compared++;
    if (state !== 2'b00 || p1_score !== 4'd0 || p2_score !== 4'd0 || winner !== 2'b00 ||
        player_row !== 4'd14 || player_col !== 5'd9) begin
      n_mismatched++; $display("[TB] FAIL mid_reset: got state %0d %0d/%0d w %0d (%0d,%0d) expected 0 0/0 0 (14,9)",
                               state, p1_score, p2_score, winner, player_row, player_col);
    end
  endtask

  // Advances the game model by one clock using the current inputs.
  task automatic model_step();
    logic [19:0] obs;
    int dr, dc, sc;
    m_reload = 0;
    m_collide = 0;
    obs = use_table ? obs_table[m_row] : obs_direct;
    case (m_state)
      0: begin
        m_row = 14; m_col = 9;
        if (start) begin m_state = 1; m_p1 = 0; m_p2 = 0; m_win = 0; m_reload = 1; end
      end
      1, 2: begin
        if (!start) begin
          m_state = 0; m_row = 14; m_col = 9;
        end else if (obs[m_col]) begin
          m_collide = 1; m_state = 3 - m_state; m_row = 14; m_col = 9;
        end else if (m_row == 0) begin
          if (m_state == 1) begin m_p1++; sc = m_p1; end else begin m_p2++; sc = m_p2; end
          if (sc == 10) begin m_win = m_state; m_state = 3; end
          else m_state = 3 - m_state;
          m_row = 14; m_col = 9;
        end else if (move_tick) begin
          dr = 0; dc = 0;
          if (btnD && !btnU) dr = 1;
          else if (btnU && !btnD) dr = -1;
          else if (btnR && !btnL) dc = 1;
          else if (btnL && !btnR) dc = -1;
          m_row = (m_row + dr < 0) ? 0 : (m_row + dr > ROWS - 1) ? ROWS - 1 : m_row + dr;
          m_col = (m_col + dc < 0) ? 0 : (m_col + dc > COLS - 1) ? COLS - 1 : m_col + dc;
        end
      end
      default: if (!start) m_state = 0;
    endcase
  endtask

  task automatic test_random();
    for (int r = 0; r < 16; r++) obs_table[r] = $urandom() & $urandom() & $urandom();
    obs_table[14] = '0;
    use_table = 1'b1;
    start = 1'b0;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    m_state = 0; m_row = 14; m_col = 9; m_p1 = 0; m_p2 = 0; m_win = 0; m_reload = 0; m_collide = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      start     = ($urandom_range(0, 149) != 0);
      move_tick = ($urandom_range(0, 2) == 0);
      btnU      = ($urandom_range(0, 9) < 7);
      btnD      = ($urandom_range(0, 9) < 2);
      btnL      = ($urandom_range(0, 9) < 3);
      btnR      = ($urandom_range(0, 9) < 3);
      model_step();
      cycle();
      n_compared++;
      if (state !== 2'(m_state) || obs_shift_en !== (m_state == 1 || m_state == 2)) begin
        n_mismatched++; $display("[TB] FAIL rnd_state@%0d: got %0d shift %b expected %0d", cyc, state, obs_shift_en, m_state);
      end
      n_compared++;
      if (player_row !== 4'(m_row) || player_col !== 5'(m_col)) begin
        n_mismatched++; $display("[TB] FAIL rnd_pos@%0d: got (%0d,%0d) expected (%0d,%0d)", cyc, player_row, player_col, m_row, m_col);
      end
      n_compared++;
      if (p1_score !== 4'(m_p1) || p2_score !== 4'(m_p2) || winner !== 2'(m_win)) begin
        n_mismatched++; $display("[TB] FAIL rnd_score@%0d: got %0d/%0d w%0d expected %0d/%0d w%0d",
                                 cyc, p1_score, p2_score, winner, m_p1, m_p2, m_win);
      end
      n_compared++;
      if (collide !== 1'(m_collide) || obs_reload !== 1'(m_reload)) begin
        n_mismatched++; $display("[TB] FAIL rnd_pulse@%0d: got c%b r%b expected c%0d r%0d", cyc, collide, obs_reload, m_collide, m_reload);
      end
    end
    {move_tick, btnU, btnD, btnL, btnR} = 5'b0;
    use_table = 1'b0;
  endtask

  initial begin
    $display("[TB] frog_game_ctrl bench starting");
    test_reset();
    test_start();
    test_goal();
    test_collision();
    test_saturation();
    test_win();
    test_reset_midgame();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
